// File: rtl/line_clear_pkg.sv
// line_clear_pkg: shared playfield geometry, the line-clear FSM state type
// and the full-row constant. The piece-lock logic and the playfield RAM
// import this package as well.
package line_clear_pkg;

  localparam int ROWS       = 16;  // playfield height, row 0 is the top
  localparam int COLS       = 10;  // playfield width, one RAM word per row
  localparam int ADDR_W     = 4;   // row address width
  localparam int SPAWN_ROWS = 2;   // rows 0..SPAWN_ROWS-1 form the spawn zone

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EVAL,
    FILL,
    CHECK,
    DONE
  } lc_state_e;

  localparam logic [COLS-1:0] ROW_FULL = '1;

endpackage

// File: rtl/line_clear_if.sv
// line_clear_if: groups the line-clear handshake, the playfield RAM port
// and the score outputs.
//   start        piece-lock request (one cycle)
//   busy/done    scan in progress / end-of-scan pulse
//   rd_*         synchronous RAM read port, rd_data one cycle after rd_en
//   wr_*         RAM write port
//   aligne       one pulse per cleared row, to the score counter
//   perdu        sticky game-over level
// master: the line_clear block. slave: lock logic, RAM and score display.
interface line_clear_if #(
  parameter int COLS   = line_clear_pkg::COLS,
  parameter int ADDR_W = line_clear_pkg::ADDR_W
);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [COLS-1:0]   rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [COLS-1:0]   wr_data;
  logic              aligne;
  logic              perdu;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, aligne, perdu
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, aligne, perdu
  );

endinterface

// File: rtl/line_clear.sv
// line_clear: after each piece lock, scans the playfield bottom-up, drops
// every full row and compacts the rows above it downward in place, then
// zero-fills the vacated top rows. Pulses aligne once per removed row and
// raises the sticky perdu level when a non-empty row lands in the spawn zone.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    line_clear_if.master (handshake, RAM port, score outputs)
//
// state | meaning
// IDLE  | waiting for start (ignored once perdu is set)
// READ  | issue RAM read of row r
// EVAL  | rd_data valid: drop a full row or copy it down to row wp
// FILL  | write zeros into the vacated top rows, one per cycle
// CHECK | fold the spill flag into perdu
// DONE  | one-cycle done pulse
module line_clear
  import line_clear_pkg::*;
#(
  parameter int ROWS_P       = ROWS,
  parameter int COLS_P       = COLS,
  parameter int ADDR_W_P     = ADDR_W,
  parameter int SPAWN_ROWS_P = SPAWN_ROWS
) (
  input logic         clk,
  input logic         reset,
  line_clear_if.master bus
);

  lc_state_e             state_q, state_d;
  logic [ADDR_W_P-1:0]   r_q, r_d;
  logic [ADDR_W_P-1:0]   wp_q, wp_d;
  logic [ADDR_W_P:0]     cleared_q, cleared_d;
  logic                  spill_q, spill_d;
  logic                  perdu_q, perdu_d;

  logic                  busy_o;
  logic                  done_o;
  logic                  rd_en_o;
  logic [ADDR_W_P-1:0]   rd_addr_o;
  logic                  wr_en_o;
  logic [ADDR_W_P-1:0]   wr_addr_o;
  logic [COLS_P-1:0]     wr_data_o;
  logic                  aligne_o;

  logic                  row_full;
  logic                  row_empty;

  assign row_full  = &bus.rd_data;
  assign row_empty = (bus.rd_data == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      r_q       <= '0;
      wp_q      <= '0;
      cleared_q <= '0;
      spill_q   <= 1'b0;
      perdu_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      wp_q      <= wp_d;
      cleared_q <= cleared_d;
      spill_q   <= spill_d;
      perdu_q   <= perdu_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    wp_d      = wp_q;
    cleared_d = cleared_q;
    spill_d   = spill_q;
    perdu_d   = perdu_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    aligne_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !perdu_q) begin
          r_d       = ADDR_W_P'(ROWS_P - 1);
          wp_d      = ADDR_W_P'(ROWS_P - 1);
          cleared_d = '0;
          spill_d   = 1'b0;
          state_d   = READ;
        end
      end

      READ: begin
        busy_o    = 1'b1;
        rd_en_o   = 1'b1;
        rd_addr_o = r_q;
        state_d   = EVAL;
      end

      EVAL: begin
        busy_o = 1'b1;
        if (row_full) begin
          aligne_o  = 1'b1;
          cleared_d = cleared_q + (ADDR_W_P+1)'(1);
        end else begin
          wr_en_o   = 1'b1;
          wr_addr_o = wp_q;
          wr_data_o = bus.rd_data;
          wp_d      = wp_q - ADDR_W_P'(1);
          // wp is the destination row, so this catches rows landing in spawn
          if (!row_empty && (wp_q < ADDR_W_P'(SPAWN_ROWS_P)))
            spill_d = 1'b1;
        end
        // r==0 ends the scan; cleared_d includes a clear of row 0 itself
        if (r_q == '0)
          state_d = (cleared_d == '0) ? CHECK : FILL;
        else begin
          r_d     = r_q - ADDR_W_P'(1);
          state_d = READ;
        end
      end

      FILL: begin
        busy_o    = 1'b1;
        wr_en_o   = 1'b1;
        wr_addr_o = wp_q;
        wp_d      = wp_q - ADDR_W_P'(1);
        if (wp_q == '0)
          state_d = CHECK;
      end

      CHECK: begin
        busy_o  = 1'b1;
        perdu_d = perdu_q | spill_q;
        state_d = DONE;
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy_o;
  assign bus.done    = done_o;
  assign bus.rd_en   = rd_en_o;
  assign bus.rd_addr = rd_addr_o;
  assign bus.wr_en   = wr_en_o;
  assign bus.wr_addr = wr_addr_o;
  assign bus.wr_data = wr_data_o;
  assign bus.aligne  = aligne_o;
  assign bus.perdu   = perdu_q;

endmodule
